// File: rtl/hilo_sequencer.sv
// Sequences a multi-cycle mult/div: start pulse, fixed-latency wait, HI/LO writeback.
// Also handles the mthi/mtlo writes and flags divide-by-zero before the datapath is started.
module hilo_sequencer #(
  parameter int LATENCY = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] regB_out,
  input  logic [31:0] hi_entrance,
  input  logic [31:0] lo_entrance,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        mdControl,
  output logic        md_start,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [5:0] COUNT_LOAD = 6'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  count, count_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        ctl_nxt, md_start_nxt, busy_nxt, done_nxt, div_zero_nxt;

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    hi_nxt       = hi_out;
    lo_nxt       = lo_out;
    ctl_nxt      = mdControl;
    md_start_nxt = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    div_zero_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (wr_hi) hi_nxt = wr_data;
        if (wr_lo) lo_nxt = wr_data;
        if (start) begin
          // A zero divisor never reaches the datapath; it is reported and dropped.
          if (op && (regB_out == 32'd0)) begin
            div_zero_nxt = 1'b1;
          end else begin
            ctl_nxt      = op;
            count_nxt    = COUNT_LOAD;
            md_start_nxt = 1'b1;
            busy_nxt     = 1'b1;
            state_nxt    = RUN;
          end
        end
      end
      RUN: begin
        if (count == 6'd0) state_nxt = WRITE;
        else               count_nxt = count - 6'd1;
      end
      WRITE: begin
        hi_nxt    = hi_entrance;
        lo_nxt    = lo_entrance;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 6'd0;
      hi_out    <= 32'd0;
      lo_out    <= 32'd0;
      mdControl <= 1'b0;
      md_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      hi_out    <= hi_nxt;
      lo_out    <= lo_nxt;
      mdControl <= ctl_nxt;
      md_start  <= md_start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      div_zero  <= div_zero_nxt;
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Bench for hilo_sequencer: IDLE vector table, then timed mult/div, abort and LATENCY=1 sequences.
`timescale 1ns/1ps
module tb_hilo_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, start1, op, wr_hi, wr_lo;
  logic [31:0] regB_out, hi_entrance, lo_entrance, wr_data;
  logic        mdControl, md_start, busy, done, div_zero;
  logic [31:0] hi_out, lo_out;
  logic        mdControl1, md_start1, busy1, done1, div_zero1;
  logic [31:0] hi_out1, lo_out1;

  always #5 clock = ~clock;

  hilo_sequencer #(.LATENCY(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .regB_out(regB_out),
    .hi_entrance(hi_entrance), .lo_entrance(lo_entrance), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .mdControl(mdControl), .md_start(md_start), .busy(busy),
    .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out));

  hilo_sequencer #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .op(op), .regB_out(regB_out),
    .hi_entrance(hi_entrance), .lo_entrance(lo_entrance), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_data(wr_data), .mdControl(mdControl1), .md_start(md_start1), .busy(busy1),
    .done(done1), .div_zero(div_zero1), .hi_out(hi_out1), .lo_out(lo_out1));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void checkb(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  typedef struct {logic [31:0] hi; logic [31:0] lo;} res_t;
  res_t sb[$];
  res_t sb1[$];
  res_t r0, r1;

  // Scoreboards: every done must match the oldest accepted operation's result.
  always @(negedge clock) begin
    checkb("done_and_div_zero", done & div_zero, 1'b0);
    if (done) begin
      check("sb_pending", sb.size(), 1);
      if (sb.size() > 0) begin
        r0 = sb.pop_front();
        check("sb_hi", hi_out, r0.hi);
        check("sb_lo", lo_out, r0.lo);
      end
    end
    if (done1) begin
      check("sb1_pending", sb1.size(), 1);
      if (sb1.size() > 0) begin
        r1 = sb1.pop_front();
        check("sb1_hi", hi_out1, r1.hi);
        check("sb1_lo", lo_out1, r1.lo);
      end
    end
  end

  typedef struct {
    logic        st;
    logic        op;
    logic [31:0] b;
    logic        wh;
    logic        wl;
    logic [31:0] wd;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_dz;
  } vec_t;

  vec_t vt[6];
  int busy_n, md_n, md_at, done_n, done_at, ctl_n;

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'hAAAA0000, 32'hAAAA0000, 32'h00000000, 1'b0};
    vt[1] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000BBBB, 32'hAAAA0000, 32'h0000BBBB, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'h0,        32'hAAAA0000, 32'h0000BBBB, 1'b1};
    vt[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0};
    vt[4] = '{1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0};
    vt[5] = '{1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 32'h0,        32'h12345678, 32'h12345678, 1'b1};

    // Reset overrides a simultaneous start and write.
    reset = 1'b1; start = 1'b1; start1 = 1'b0; op = 1'b0; wr_hi = 1'b1; wr_lo = 1'b1;
    wr_data = 32'hFFFFFFFF; regB_out = 32'd0; hi_entrance = 32'd0; lo_entrance = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    checkb("rst_busy", busy, 1'b0);
    checkb("rst_md_start", md_start, 1'b0);
    checkb("rst_done", done, 1'b0);
    checkb("rst_div_zero", div_zero, 1'b0);
    checkb("rst_mdControl", mdControl, 1'b0);
    check("rst_hi1", hi_out1, 0);
    reset = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;

    // Single-cycle IDLE behaviour: mthi/mtlo and divide-by-zero.
    for (int i = 0; i < 6; i++) begin
      start = vt[i].st; op = vt[i].op; regB_out = vt[i].b;
      wr_hi = vt[i].wh; wr_lo = vt[i].wl; wr_data = vt[i].wd;
      @(negedge clock);
      check($sformatf("vec%0d_hi", i), hi_out, vt[i].e_hi);
      check($sformatf("vec%0d_lo", i), lo_out, vt[i].e_lo);
      checkb($sformatf("vec%0d_div_zero", i), div_zero, vt[i].e_dz);
      checkb($sformatf("vec%0d_busy", i), busy, 1'b0);
      checkb($sformatf("vec%0d_md_start", i), md_start, 1'b0);
      checkb($sformatf("vec%0d_mdControl", i), mdControl, 1'b0);
    end

    // Mult with a same-cycle mtlo, a start during RUN, mtlo in RUN and in WRITE.
    hi_entrance = 32'd0; lo_entrance = 32'd15;
    start = 1'b1; op = 1'b0; regB_out = 32'd0; wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h55;
    sb.push_back('{32'd0, 32'd15});
    @(negedge clock);
    busy_n = 0; md_n = 0; md_at = 0; done_n = 0; done_at = 0; ctl_n = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (busy) busy_n++;
      if (md_start) begin md_n++; md_at = cyc; end
      if (done) begin done_n++; done_at = cyc; end
      if (mdControl) ctl_n++;
      if (cyc == 1)  check("mult_lo_write_with_start", lo_out, 32'h55);
      if (cyc == 15) check("mult_lo_run_write_ignored", lo_out, 32'h55);
      start    = (cyc == 10);
      op       = (cyc == 10);
      regB_out = 32'd5;
      wr_lo    = (cyc == 12) || (cyc == 33);
      wr_data  = (cyc == 12) ? 32'hDEAD : 32'hBEEF;
    end
    start = 1'b0; op = 1'b0; wr_lo = 1'b0;
    check("mult_busy_cycles", busy_n, 33);
    check("mult_md_start_count", md_n, 1);
    check("mult_md_start_cycle", md_at, 1);
    check("mult_done_count", done_n, 1);
    check("mult_done_cycle", done_at, 34);
    check("mult_mdControl_ones", ctl_n, 0);
    check("mult_hi", hi_out, 0);
    check("mult_lo", lo_out, 15);

    // Div aborted by reset at cycle 20 of RUN.
    hi_entrance = 32'h0BAD; lo_entrance = 32'h0BAD;
    start = 1'b1; op = 1'b1; regB_out = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkb("abort_busy", busy, 1'b0);
    checkb("abort_done", done, 1'b0);
    checkb("abort_mdControl", mdControl, 1'b0);
    check("abort_hi", hi_out, 0);
    check("abort_lo", lo_out, 0);
    done_n = 0; busy_n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    check("abort_no_done", done_n, 0);
    check("abort_no_busy", busy_n, 0);

    // Following div completes normally.
    hi_entrance = 32'd7; lo_entrance = 32'd9;
    start = 1'b1; op = 1'b1; regB_out = 32'd3;
    sb.push_back('{32'd7, 32'd9});
    busy_n = 0; done_n = 0; done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = cyc; end
    end
    check("div_busy_cycles", busy_n, 33);
    check("div_done_count", done_n, 1);
    check("div_done_cycle", done_at, 34);
    checkb("div_mdControl_held", mdControl, 1'b1);
    check("div_hi", hi_out, 7);
    check("div_lo", lo_out, 9);

    // LATENCY=1 instance.
    hi_entrance = 32'hCAFE; lo_entrance = 32'hF00D;
    start1 = 1'b1; op = 1'b0;
    sb1.push_back('{32'hCAFE, 32'hF00D});
    busy_n = 0; md_n = 0; md_at = 0; done_n = 0; done_at = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      start1 = 1'b0;
      if (busy1) busy_n++;
      if (md_start1) begin md_n++; md_at = cyc; end
      if (done1) begin done_n++; done_at = cyc; end
    end
    check("lat1_busy_cycles", busy_n, 2);
    check("lat1_md_start_cycle", md_at, 1);
    check("lat1_done_count", done_n, 1);
    check("lat1_done_cycle", done_at, 3);
    check("lat1_hi", hi_out1, 32'hCAFE);
    check("lat1_lo", lo_out1, 32'hF00D);

    @(negedge clock);
    check("sb_drained", sb.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
